// File: rtl/fetch_ctrl_if.sv
// Fetch stage bundle: ID-side redirect/hold controls, the instruction memory
// port and the IF/ID pipeline register outputs.
interface fetch_ctrl_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr_in;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;

  // fetch unit side
  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, instr_in,
    output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, halted
  );

  // pipeline / memory side
  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, instr_in,
    input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, halted
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, redirect/stall priority,
// IF/ID pipeline register and a sticky halt once the PC leaves memory.
module fetch_ctrl #(
  parameter int          MEM_WORDS = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_ctrl_if.master  bus
);

  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {START, RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc4;
  ifid_t       ifid_q, ifid_d;
  logic        halted_q, halted_d;
  logic        in_range;

  assign pc4      = pc_q + 32'd4;
  assign in_range = {1'b0, pc_q} < MEM_BYTES;

  // State, PC, IF/ID and halt flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= START;
      pc_q     <= RESET_PC;
      ifid_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ifid_q   <= ifid_d;
      halted_q <= halted_d;
    end
  end

  // Next-state, next-PC and IF/ID load: redirect > stall > range halt > fetch
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    unique case (state_q)
      START: begin
        ifid_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        if (bus.branch_taken) begin
          pc_d   = {bus.branch_target[31:2], 2'b00};
          ifid_d = '0;
        end else if (bus.jump) begin
          pc_d   = {bus.jump_target[31:2], 2'b00};
          ifid_d = '0;
        end else if (bus.stall) begin
          // hold PC and IF/ID
        end else if (!in_range) begin
          ifid_d  = '0;
          state_d = HALT;
        end else begin
          ifid_d = '{instr: bus.instr_in, pc4: pc4, valid: 1'b1};
          pc_d   = pc4;
        end
      end
      HALT: begin
        ifid_d = '0;
      end
      default: begin
        ifid_d  = '0;
        state_d = START;
      end
    endcase
    halted_d = (state_d == HALT);
  end

  assign bus.pc          = pc_q;
  assign bus.imem_addr   = pc_q;
  assign bus.if_id_instr = ifid_q.instr;
  assign bus.if_id_pc4   = ifid_q.pc4;
  assign bus.if_id_valid = ifid_q.valid;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized redirect/stall
// traffic, all checked against a behavioural model of the fetch rules.
module tb_fetch_ctrl;

  localparam int MEM_WORDS = 32;
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS * 4);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec = 0;
  int   err = 0;

  logic [31:0] mem [MEM_WORDS];

  fetch_ctrl_if bus();

  fetch_ctrl #(.MEM_WORDS(MEM_WORDS), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // combinational instruction memory; junk beyond the populated range
  assign bus.instr_in = (bus.imem_addr < MEM_LIMIT) ? mem[bus.imem_addr[6:2]] : 32'hDEAD_BEEF;

  // behavioural model
  localparam int M_START = 0, M_RUN = 1, M_HALT = 2;
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halted;

  function automatic logic [129:0] obs();
    return {bus.pc, bus.imem_addr, bus.if_id_instr, bus.if_id_pc4, bus.if_id_valid, bus.halted};
  endfunction

  function automatic logic [129:0] expv();
    return {m_pc, m_pc, m_instr, m_pc4, m_valid, m_halted};
  endfunction

  task automatic model_reset();
    m_phase = M_START; m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halted = 0;
  endtask

  task automatic model_bubble();
    m_instr = 0; m_pc4 = 0; m_valid = 0;
  endtask

  task automatic model_tick();
    if (m_phase == M_START) begin
      model_bubble();
      m_phase = M_RUN;
    end else if (m_phase == M_RUN) begin
      if (bus.branch_taken) begin
        m_pc = bus.branch_target & ~32'h3; model_bubble();
      end else if (bus.jump) begin
        m_pc = bus.jump_target & ~32'h3; model_bubble();
      end else if (bus.stall) begin
        // nothing moves
      end else if (m_pc >= MEM_LIMIT) begin
        model_bubble(); m_phase = M_HALT;
      end else begin
        m_instr = mem[m_pc / 4]; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
      end
    end else begin
      model_bubble();
    end
    m_halted = (m_phase == M_HALT);
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.branch_taken = 0; bus.jump = 0;
    bus.branch_target = 0; bus.jump_target = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; model_reset();
    #3;
    vec++;
    if (obs() !== expv()) begin err++; $display("FAIL reset_state got=%h want=%h", obs(), expv()); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = i * 3;
    idle_inputs();
    do_reset();
    step();
    vec++;
    if (bus.if_id_valid !== 1'b0 || bus.pc !== 32'h0 || obs() !== expv()) begin
      err++; $display("FAIL seq_start_bubble got=%h want=%h", obs(), expv());
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vec++;
      if (bus.if_id_instr !== 32'(k * 3) || bus.if_id_pc4 !== 32'(4 * (k + 1)) ||
          bus.if_id_valid !== 1'b1 || obs() !== expv()) begin
        err++; $display("FAIL seq_fetch%0d got=%h want=%h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_redirect_priority();
    step();  // pc 0x0C -> 0x10
    vec++;
    if (bus.pc !== 32'h10) begin err++; $display("FAIL prio_setup pc got=%h want=10", bus.pc); end
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h2C;
    bus.jump = 1; bus.jump_target = 32'h40;
    step();
    vec++;
    if (bus.pc !== 32'h2C || bus.if_id_valid !== 1'b0 || obs() !== expv()) begin
      err++; $display("FAIL redirect_prio got=%h want=%h", obs(), expv());
    end
    idle_inputs();
    step();
    vec++;
    if (obs() !== expv()) begin err++; $display("FAIL post_branch_fetch got=%h want=%h", obs(), expv()); end
  endtask

  task automatic test_alignment();
    bus.jump = 1; bus.jump_target = 32'h47;
    step();
    idle_inputs();
    vec++;
    if (bus.pc !== 32'h44 || obs() !== expv()) begin
      err++; $display("FAIL jump_align got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_stall();
    logic [129:0] snap;
    idle_inputs();
    do_reset();
    step(); step(); step();
    snap = obs();
    vec++;
    if (bus.pc !== 32'h08) begin err++; $display("FAIL stall_setup pc got=%h want=8", bus.pc); end
    bus.stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      vec++;
      if (obs() !== snap || obs() !== expv()) begin
        err++; $display("FAIL stall_hold%0d got=%h want=%h", k, obs(), snap);
      end
    end
    bus.stall = 0;
    step();
    vec++;
    if (bus.pc !== 32'h0C || obs() !== expv()) begin
      err++; $display("FAIL stall_resume got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_halt();
    idle_inputs();
    do_reset();
    step();
    for (int k = 0; k < MEM_WORDS; k++) step();
    vec++;
    if (bus.pc !== 32'h80 || bus.halted !== 1'b0 || obs() !== expv()) begin
      err++; $display("FAIL halt_reach got=%h want=%h", obs(), expv());
    end
    step();
    vec++;
    if (bus.halted !== 1'b1 || bus.if_id_valid !== 1'b0 || bus.pc !== 32'h80 || obs() !== expv()) begin
      err++; $display("FAIL halt_enter got=%h want=%h", obs(), expv());
    end
    bus.branch_taken = 1; bus.branch_target = 32'h0; bus.stall = 1;
    step();
    vec++;
    if (bus.pc !== 32'h80 || bus.halted !== 1'b1 || obs() !== expv()) begin
      err++; $display("FAIL halt_ignores_branch got=%h want=%h", obs(), expv());
    end
    // async reset while halted and stalled
    #2;
    rst_n = 0; model_reset();
    #1;
    vec++;
    if (bus.pc !== 32'h0 || bus.halted !== 1'b0 || obs() !== expv()) begin
      err++; $display("FAIL halt_async_reset got=%h want=%h", obs(), expv());
    end
    idle_inputs();
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_oor_redirect();
    idle_inputs();
    do_reset();
    step();
    bus.branch_taken = 1; bus.branch_target = 32'h100;
    step();
    idle_inputs();
    vec++;
    if (bus.pc !== 32'h100 || bus.halted !== 1'b0 || obs() !== expv()) begin
      err++; $display("FAIL oor_redirect got=%h want=%h", obs(), expv());
    end
    step();
    vec++;
    if (bus.pc !== 32'h100 || bus.halted !== 1'b1 || obs() !== expv()) begin
      err++; $display("FAIL oor_halt got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    idle_inputs();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bus.stall         = ($urandom_range(0, 9) < 3);
      bus.branch_taken  = ($urandom_range(0, 15) == 0);
      bus.branch_target = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h8F));
      bus.jump          = ($urandom_range(0, 15) == 0);
      bus.jump_target   = 32'($urandom_range(0, 32'h8F));
      step();
      vec++;
      if (obs() !== expv()) begin err++; $display("FAIL random_c%0d got=%h want=%h", n, obs(), expv()); end
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        rst_n = 0; model_reset();
        #1;
        vec++;
        if (obs() !== expv()) begin err++; $display("FAIL random_rst%0d got=%h want=%h", n, obs(), expv()); end
        @(negedge clk); rst_n = 1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 0;
    test_reset();
    test_sequential();
    test_redirect_priority();
    test_alignment();
    test_stall();
    test_halt();
    test_oor_redirect();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
